raster_scan_gen: RTL and testbench
==================================

# raster_scan_gen

Raster coordinate generator that feeds the zoomer stage: it walks a programmable horizontal/vertical scan and presents 8-bit `Xcoord`/`Ycoord` pairs with `VALID`, plus display syncs. It also latches a frame-stable `Zoom` value so the zoomer never sees a zoom change in the middle of a frame. It sits directly upstream of the zoomer, whose `Xcoord`, `Ycoord`, `Zoom` and `ENB` inputs are driven straight from this block.

## Interface

**Parameters**
- `H_ACTIVE`, 256: visible pixels per line (≤256).
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 32: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 240: visible lines per frame (≤256).
- `V_FP`, 3 / `V_SYNC`, 4 / `V_BP`, 15: vertical porches and sync width, in lines.
- `PIX_DIV`, 2: number of ACLK cycles per pixel (≥1).

**Ports**
- `ACLK` in 1: the single clock; all logic is on its rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `ENB` in 1: run enable. While low, the scan freezes.
- `ZOOM_IN` in 8: requested zoom, sampled once per frame.
- `Xcoord` out 8: current horizontal coordinate.
- `Ycoord` out 8: current vertical coordinate.
- `Zoom` out 8: frame-stable zoom, fed to the zoomer.
- `VALID` out 1: the coordinate pair is inside the active area.
- `HSYNC_N` out 1: horizontal sync, active low.
- `VSYNC_N` out 1: vertical sync, active low.
- `LINE_START` out 1: one-ACLK pulse on the first pixel of each active line.
- `FRAME_START` out 1: one-ACLK pulse on pixel (0,0).

## Operation

- Internal state:
  - `div` counts 0..PIX_DIV-1.
  - `hcnt` and `vcnt` are 10-bit counters.
  - H_TOTAL = sum of the four H parameters (352 by default); V_TOTAL likewise (262 by default).
- Counting, when ENB=1:
  - `div` increments and wraps at PIX_DIV-1.
  - A pixel tick occurs when div==PIX_DIV-1.
  - On a tick, `hcnt` increments. At H_TOTAL-1 it wraps to 0 and `vcnt` increments; `vcnt` wraps at V_TOTAL-1.
- ENB=0:
  - `div`, `hcnt`, `vcnt`, `Zoom`, HSYNC_N and VSYNC_N hold their values.
  - VALID, LINE_START and FRAME_START are driven 0.
  - Xcoord and Ycoord hold.
  - When ENB returns to 1, the scan resumes from the frozen position.
- Registered outputs while ENB=1. Each output in cycle t+1 is a function of the counters in cycle t:
  - VALID = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - Xcoord = hcnt[7:0] and Ycoord = vcnt[7:0] when VALID, otherwise 0.
  - HSYNC_N = 0 iff H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VSYNC_N is the same rule applied to `vcnt` with the V parameters.
  - LINE_START = (hcnt==0) && (vcnt < V_ACTIVE) && (div==0).
  - FRAME_START = (hcnt==0) && (vcnt==0) && (div==0).
- Zoom latch:
  - `Zoom` <= ZOOM_IN when ENB, div==0, hcnt==0 and vcnt==V_ACTIVE (first blank line).
  - `Zoom` is therefore constant for every active pixel of a frame.
  - ZOOM_IN changes at any other time are ignored until the next latch point.
- Reset (asynchronous, ARESETN=0):
  - `div`, `hcnt`, `vcnt` = 0.
  - Xcoord = Ycoord = Zoom = 0.
  - VALID = LINE_START = FRAME_START = 0.
  - HSYNC_N = VSYNC_N = 1.
  - Reset in the middle of a line or frame aborts it. After release, the scan restarts at (0,0) and the first frame uses Zoom=0.

## Timing

- Latency: outputs lag the counters by exactly one ACLK.
- After ARESETN deasserts with ENB=1, the first rising edge gives VALID=1, X=0, Y=0 and FRAME_START=1.
- Each coordinate is held for PIX_DIV ACLK cycles. LINE_START and FRAME_START are high only in the first of those cycles.
- Line length is H_TOTAL·PIX_DIV ACLK (704 by default). Frame length is H_TOTAL·V_TOTAL·PIX_DIV (184448 by default).
- No handshake: the zoomer is a pure consumer and cannot apply backpressure. VALID qualifies each pair.
- With PIX_DIV=1, `div` is constant 0 and every ACLK is a tick.

## Structure

- Shared package `raster_pkg`:
  - default timing constants;
  - H_TOTAL and V_TOTAL derivation functions;
  - counter width (10);
  - coordinate width (8), shared with the zoomer.
- One natural sub-module, `pix_tick_div`: the `div` counter plus the tick output, gated by ENB and reset by ARESETN.
- Counters, decode logic and output registers stay in the top module.

## Test plan

1. **Reset values:** hold ARESETN=0 with ENB=1 → Xcoord=0, Ycoord=0, Zoom=0, VALID=0, HSYNC_N=1, VSYNC_N=1. Release reset → next edge gives VALID=1, (0,0), FRAME_START for 1 cycle.
2. **First line, default parameters:**
   - X steps 0,1,…,255, each held 2 cycles, with Y=0.
   - VALID falls at ACLK 512 after release.
   - HSYNC_N is low from cycle 544 to 607.
   - LINE_START recurs every 704 cycles.
3. **Frame wrap:**
   - VSYNC_N is low for lines 243–246.
   - FRAME_START re-fires at cycle 184448 with (0,0).
   - VALID stays 0 for all of lines 240–261.
4. **Zoom latch:**
   - ZOOM_IN=4 applied at line 10 → Zoom stays 0 until line 240, then 4.
   - ZOOM_IN pulsed to 7 for one cycle mid-frame → ignored.
5. **ENB freeze:** drop ENB at X=100 for 50 cycles → VALID=0 and counters hold during the gap. On re-enable, output resumes at X=100 with no skipped or duplicated coordinates.
6. **Reset mid-operation:** assert ARESETN at line 120, X=37 → outputs reach reset values asynchronously (without waiting for a clock edge). After release, the scan restarts at (0,0) with FRAME_START.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster timing defaults, widths and derivation helpers for the
// scan generator and the downstream zoomer.
package raster_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COORD_W = 8;

  localparam int unsigned DEF_H_ACTIVE = 256;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 32;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 15;
  localparam int unsigned DEF_PIX_DIV  = 2;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // A divide-by-1 still needs a one-bit register to keep the code uniform.
  function automatic int unsigned div_width(input int unsigned pix_div);
    return (pix_div > 1) ? $clog2(pix_div) : 1;
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel clock-enable divider: counts ACLK cycles per pixel and flags the
// last cycle of each pixel as the tick.
module pix_tick_div
  import raster_pkg::*;
#(
  parameter int unsigned PIX_DIV = DEF_PIX_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enb_i,
  output logic tick_o,
  output logic div_zero_o
);

  localparam int unsigned   DW       = div_width(PIX_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (enb_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o     = enb_i && (div_q == DIV_LAST);
  assign div_zero_o = (div_q == '0);

endmodule

// File: rtl/raster_scan_gen.sv
// Raster scan generator: walks H/V counters, emits registered coordinates,
// syncs and start pulses, and latches a frame-stable zoom for the zoomer.
module raster_scan_gen
  import raster_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               ENB,
  input  logic [COORD_W-1:0] ZOOM_IN,
  output logic [COORD_W-1:0] Xcoord,
  output logic [COORD_W-1:0] Ycoord,
  output logic [COORD_W-1:0] Zoom,
  output logic               VALID,
  output logic               HSYNC_N,
  output logic               VSYNC_N,
  output logic               LINE_START,
  output logic               FRAME_START
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic tick, div_zero;

  pix_tick_div #(
    .PIX_DIV(PIX_DIV)
  ) u_div (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .enb_i      (ENB),
    .tick_o     (tick),
    .div_zero_o (div_zero)
  );

  cnt_t   hcnt_q, hcnt_d;
  cnt_t   vcnt_q, vcnt_d;
  coord_t x_q, y_q, zoom_q;
  logic   valid_q, hs_n_q, vs_n_q, ls_q, fs_q;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  logic active, hs_on, vs_on, line_first, zoom_latch;

  always_comb begin
    active     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_on      = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs_on      = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    line_first = (hcnt_q == '0) && div_zero;
    zoom_latch = line_first && (vcnt_q == V_ACT);
  end

  // While frozen, coordinates and syncs hold but qualifiers drop to 0.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      x_q     <= '0;
      y_q     <= '0;
      zoom_q  <= '0;
      valid_q <= 1'b0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (ENB) begin
      valid_q <= active;
      x_q     <= active ? hcnt_q[COORD_W-1:0] : '0;
      y_q     <= active ? vcnt_q[COORD_W-1:0] : '0;
      hs_n_q  <= !hs_on;
      vs_n_q  <= !vs_on;
      ls_q    <= line_first && (vcnt_q < V_ACT);
      fs_q    <= line_first && (vcnt_q == '0);
      if (zoom_latch) begin
        zoom_q <= ZOOM_IN;
      end
    end else begin
      valid_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end
  end

  assign Xcoord      = x_q;
  assign Ycoord      = y_q;
  assign Zoom        = zoom_q;
  assign VALID       = valid_q;
  assign HSYNC_N     = hs_n_q;
  assign VSYNC_N     = vs_n_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Directed bench for raster_scan_gen: a reduced-timing instance covers whole
// frames, a default instance covers the first full line, a PIX_DIV=1 instance
// covers the undivided case.
module tb_raster_scan_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enb = 1'b1;
  logic [7:0] zoom_in = 8'd0;

  logic [7:0] s_x, s_y, s_z, d_x, d_y, d_z, u_x, u_y, u_z;
  logic       s_v, s_hs, s_vs, s_ls, s_fs;
  logic       d_v, d_hs, d_vs, d_ls, d_fs;
  logic       u_v, u_hs, u_vs, u_ls, u_fs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Small instance: H_TOTAL=24, V_TOTAL=16, frame = 768 ACLK.
  raster_scan_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIX_DIV(2)
  ) u_small (
    .ACLK(clk), .ARESETN(rst_n), .ENB(enb), .ZOOM_IN(zoom_in),
    .Xcoord(s_x), .Ycoord(s_y), .Zoom(s_z), .VALID(s_v),
    .HSYNC_N(s_hs), .VSYNC_N(s_vs), .LINE_START(s_ls), .FRAME_START(s_fs)
  );

  raster_scan_gen u_dflt (
    .ACLK(clk), .ARESETN(rst_n), .ENB(enb), .ZOOM_IN(zoom_in),
    .Xcoord(d_x), .Ycoord(d_y), .Zoom(d_z), .VALID(d_v),
    .HSYNC_N(d_hs), .VSYNC_N(d_vs), .LINE_START(d_ls), .FRAME_START(d_fs)
  );

  raster_scan_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIX_DIV(1)
  ) u_div1 (
    .ACLK(clk), .ARESETN(rst_n), .ENB(enb), .ZOOM_IN(zoom_in),
    .Xcoord(u_x), .Ycoord(u_y), .Zoom(u_z), .VALID(u_v),
    .HSYNC_N(u_hs), .VSYNC_N(u_vs), .LINE_START(u_ls), .FRAME_START(u_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p, ph, h, v, ev, ex;

    // Reset values while ARESETN held low with ENB=1
    rst_n = 1'b0;
    enb = 1'b1;
    zoom_in = 8'd0;
    repeat (3) step();
    chk("rst_x", 32'(s_x), 0);
    chk("rst_y", 32'(s_y), 0);
    chk("rst_zoom", 32'(s_z), 0);
    chk("rst_valid", 32'(s_v), 0);
    chk("rst_hs", 32'(s_hs), 1);
    chk("rst_vs", 32'(s_vs), 1);
    chk("rst_ls", 32'(s_ls), 0);
    chk("rst_fs", 32'(s_fs), 0);
    chk("rst_d_valid", 32'(d_v), 0);
    chk("rst_d_hs", 32'(d_hs), 1);

    // Release; sample e corresponds to the e-th rising edge after release
    rst_n = 1'b1;
    for (int e = 0; e <= 768; e++) begin
      step();

      p  = e / 2;
      ph = e % 2;
      h  = p % 24;
      v  = (p / 24) % 16;
      ev = (h < 16 && v < 10) ? 1 : 0;
      chk($sformatf("s_valid@%0d", e), 32'(s_v), ev);
      chk($sformatf("s_x@%0d", e), 32'(s_x), ev ? h : 0);
      chk($sformatf("s_y@%0d", e), 32'(s_y), ev ? v : 0);
      chk($sformatf("s_hs@%0d", e), 32'(s_hs), (h >= 18 && h < 21) ? 0 : 1);
      chk($sformatf("s_vs@%0d", e), 32'(s_vs), (v >= 12 && v < 14) ? 0 : 1);
      chk($sformatf("s_ls@%0d", e), 32'(s_ls), (h == 0 && v < 10 && ph == 0) ? 1 : 0);
      chk($sformatf("s_fs@%0d", e), 32'(s_fs), (h == 0 && v == 0 && ph == 0) ? 1 : 0);
      chk($sformatf("s_zoom@%0d", e), 32'(s_z), (e >= 480) ? 4 : 0);

      if (e <= 704) begin
        h  = p % 352;
        v  = p / 352;
        ev = (h < 256) ? 1 : 0;
        chk($sformatf("d_valid@%0d", e), 32'(d_v), ev);
        chk($sformatf("d_x@%0d", e), 32'(d_x), ev ? h : 0);
        chk($sformatf("d_y@%0d", e), 32'(d_y), ev ? v : 0);
        chk($sformatf("d_hs@%0d", e), 32'(d_hs), (h >= 272 && h < 304) ? 0 : 1);
        chk($sformatf("d_vs@%0d", e), 32'(d_vs), 1);
        chk($sformatf("d_ls@%0d", e), 32'(d_ls), (h == 0 && ph == 0) ? 1 : 0);
        chk($sformatf("d_fs@%0d", e), 32'(d_fs), (e == 0) ? 1 : 0);
        chk($sformatf("d_zoom@%0d", e), 32'(d_z), 0);
      end

      h  = e % 24;
      v  = (e / 24) % 16;
      ex = (h < 16 && v < 10) ? 1 : 0;
      chk($sformatf("u_valid@%0d", e), 32'(u_v), ex);
      chk($sformatf("u_x@%0d", e), 32'(u_x), ex ? h : 0);
      chk($sformatf("u_y@%0d", e), 32'(u_y), ex ? v : 0);
      chk($sformatf("u_hs@%0d", e), 32'(u_hs), (h >= 18 && h < 21) ? 0 : 1);
      chk($sformatf("u_vs@%0d", e), 32'(u_vs), (v >= 12 && v < 14) ? 0 : 1);
      chk($sformatf("u_ls@%0d", e), 32'(u_ls), (h == 0 && v < 10) ? 1 : 0);
      chk($sformatf("u_fs@%0d", e), 32'(u_fs), (h == 0 && v == 0) ? 1 : 0);
      chk($sformatf("u_zoom@%0d", e), 32'(u_z), (e >= 240) ? 4 : 0);

      // Zoom request at line 3, plus a one-cycle glitch mid-frame
      if (e == 143) zoom_in = 8'd4;
      if (e == 299) zoom_in = 8'd7;
      if (e == 300) zoom_in = 8'd4;
    end

    // Advance to frame 2, line 1, X=10 (first cycle of that pixel), e=836
    repeat (68) step();
    chk("pre_freeze_x", 32'(s_x), 10);
    chk("pre_freeze_y", 32'(s_y), 1);
    chk("pre_freeze_valid", 32'(s_v), 1);
    chk("pre_freeze_zoom", 32'(s_z), 4);

    enb = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("frz_valid@%0d", k), 32'(s_v), 0);
      chk($sformatf("frz_x@%0d", k), 32'(s_x), 10);
      chk($sformatf("frz_y@%0d", k), 32'(s_y), 1);
      chk($sformatf("frz_ls@%0d", k), 32'(s_ls), 0);
      chk($sformatf("frz_hs@%0d", k), 32'(s_hs), 1);
    end

    // Resume: second cycle of X=10, then 11,11,12,12,13
    enb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("res_x@%0d", k), 32'(s_x), 10 + (k + 1) / 2);
      chk($sformatf("res_y@%0d", k), 32'(s_y), 1);
      chk($sformatf("res_valid@%0d", k), 32'(s_v), 1);
    end

    // Asynchronous reset mid-cycle, checked before the next clock edge
    rst_n = 1'b0;
    #2;
    chk("arst_x", 32'(s_x), 0);
    chk("arst_y", 32'(s_y), 0);
    chk("arst_zoom", 32'(s_z), 0);
    chk("arst_valid", 32'(s_v), 0);
    chk("arst_hs", 32'(s_hs), 1);
    chk("arst_vs", 32'(s_vs), 1);
    chk("arst_ls", 32'(s_ls), 0);
    chk("arst_fs", 32'(s_fs), 0);
    repeat (2) step();
    rst_n = 1'b1;

    step();
    chk("rel_fs", 32'(s_fs), 1);
    chk("rel_ls", 32'(s_ls), 1);
    chk("rel_valid", 32'(s_v), 1);
    chk("rel_x", 32'(s_x), 0);
    chk("rel_y", 32'(s_y), 0);
    chk("rel_zoom", 32'(s_z), 0);
    step();
    chk("rel1_fs", 32'(s_fs), 0);
    chk("rel1_x", 32'(s_x), 0);
    step();
    chk("rel2_x", 32'(s_x), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
